// File: rtl/vmem_fb.sv
// Shared-clock frame buffer: registered read, byte-masked writes and a fill engine.
// Define VMEM_DBUF_EN for two banks with a vsync-timed front/back swap.
module vmem_fb #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int PIX_W = 24,
  parameter int HW    = 10,
  parameter int VW    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [HW-1:0]      waddr_h_i,
  input  logic [VW-1:0]      waddr_v_i,
  input  logic               we_i,
  input  logic [PIX_W/8-1:0] wmask_i,
  input  logic [PIX_W-1:0]   wdata_i,
  input  logic [HW-1:0]      raddr_h_i,
  input  logic [VW-1:0]      raddr_v_i,
  input  logic               re_i,
  output logic [PIX_W-1:0]   rdata_o,
  output logic               rvalid_o,
  input  logic               clr_req_i,
  input  logic [PIX_W-1:0]   clr_color_i,
  output logic               clr_busy_o,
  output logic               clr_done_o,
  input  logic               vsync_i,
  input  logic               swap_req_i,
  output logic               swap_pending_o,
  output logic               front_sel_o
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int LANES = PIX_W / 8;
`ifdef VMEM_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int MW = (NB * DEPTH > 1) ? $clog2(NB * DEPTH) : 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} clr_state_t;

  clr_state_t       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [PIX_W-1:0] color, color_n;
  logic             busy;
  logic             front, wbank;

  logic [PIX_W-1:0] mem [NB*DEPTH];
  logic             wr_en;
  logic [MW-1:0]    wr_addr, rd_addr;
  logic [PIX_W-1:0] wr_data;
  logic [LANES-1:0] wr_mask;
  logic             rd_in;

  // Banks are stacked linearly: bank b occupies [b*DEPTH, (b+1)*DEPTH).
  function automatic logic [MW-1:0] mem_addr(input logic bank, input logic [VW-1:0] v,
                                             input logic [HW-1:0] h);
    return MW'(int'(bank) * DEPTH + int'(v) * H_RES + int'(h));
  endfunction

  function automatic logic in_range(input logic [VW-1:0] v, input logic [HW-1:0] h);
    return (int'(h) < H_RES) && (int'(v) < V_RES);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      color <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      color <= color_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    color_n    = color;
    busy       = 1'b0;
    clr_done_o = 1'b0;
    unique case (state)
      IDLE: if (clr_req_i) begin
        state_n = FILL;
        cnt_n   = '0;
        color_n = clr_color_i;
      end
      FILL: begin
        busy  = 1'b1;
        cnt_n = cnt + 1'b1;
        if (int'(cnt) == DEPTH - 1) state_n = DONE;
      end
      DONE: begin
        clr_done_o = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign clr_busy_o = busy;

  // The fill engine takes the write port outright while busy.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mem_addr(wbank, waddr_v_i, waddr_h_i);
    wr_data = wdata_i;
    wr_mask = wmask_i;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = MW'(int'(wbank) * DEPTH + int'(cnt));
      wr_data = color;
      wr_mask = '1;
    end else if (we_i && in_range(waddr_v_i, waddr_h_i)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (wr_mask[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign rd_in   = in_range(raddr_v_i, raddr_h_i);
  assign rd_addr = mem_addr(front, raddr_v_i, raddr_h_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) rdata_o <= rd_in ? mem[rd_addr] : '0;
    end
  end

`ifdef VMEM_DBUF_EN
  logic vs_q, vs_d, pending, take;

  // A same-cycle request counts toward a qualifying edge.
  assign take = vs_q & ~vs_d & (pending | swap_req_i) & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      vs_d    <= 1'b0;
      pending <= 1'b0;
      front   <= 1'b0;
    end else begin
      vs_q    <= vsync_i;
      vs_d    <= vs_q;
      pending <= ~take & (pending | swap_req_i);
      if (take) front <= ~front;
    end
  end

  assign wbank          = ~front;
  assign swap_pending_o = pending;
`else
  logic unused_swap;
  assign unused_swap    = vsync_i ^ swap_req_i;
  assign front          = 1'b0;
  assign wbank          = 1'b0;
  assign swap_pending_o = 1'b0;
`endif

  assign front_sel_o = front;

endmodule

// File: tb/tb_vmem_fb.sv
// Self-checking bench for vmem_fb on a small 6x4 frame; builds with or without VMEM_DBUF_EN.
`timescale 1ns/1ps
module tb_vmem_fb;
  localparam int H = 6, V = 4, PW = 24, HW = 3, VW = 3;
  localparam int DEPTH = H * V, LN = PW / 8;
`ifdef VMEM_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [HW-1:0] waddr_h_i = '0, raddr_h_i = '0;
  logic [VW-1:0] waddr_v_i = '0, raddr_v_i = '0;
  logic          we_i = 1'b0, re_i = 1'b0, clr_req_i = 1'b0, vsync_i = 1'b0, swap_req_i = 1'b0;
  logic [LN-1:0] wmask_i = '0;
  logic [PW-1:0] wdata_i = '0, clr_color_i = '0;
  logic [PW-1:0] rdata_o;
  logic          rvalid_o, clr_busy_o, clr_done_o, swap_pending_o, front_sel_o;

  vmem_fb #(.H_RES(H), .V_RES(V), .PIX_W(PW), .HW(HW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .waddr_h_i(waddr_h_i), .waddr_v_i(waddr_v_i), .we_i(we_i), .wmask_i(wmask_i), .wdata_i(wdata_i),
    .raddr_h_i(raddr_h_i), .raddr_v_i(raddr_v_i), .re_i(re_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .clr_req_i(clr_req_i), .clr_color_i(clr_color_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .vsync_i(vsync_i), .swap_req_i(swap_req_i), .swap_pending_o(swap_pending_o), .front_sel_o(front_sel_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame contents per bank, fill as a remaining-pixel count.
  logic [PW-1:0] mm [2][DEPTH];
  logic [PW-1:0] m_rdata = '0, clr_col = '0;
  bit            m_rvalid = 0, m_done = 0, m_pend = 0, m_front = 0, vs1 = 0, vs2 = 0;
  bit            busy0, done0, rise, take, chk_en = 0;
  int            clr_left = 0, rb, wb, idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdata = '0; m_rvalid = 0; m_done = 0; m_pend = 0; m_front = 0;
      clr_left = 0; vs1 = 0; vs2 = 0;
    end else begin
      busy0 = (clr_left > 0);
      done0 = m_done;
      rise  = vs1 && !vs2;
      rb    = int'(m_front);
      wb    = DBUF ? int'(!m_front) : 0;
      m_rvalid = re_i;
      if (re_i)
        m_rdata = (int'(raddr_h_i) < H && int'(raddr_v_i) < V)
                  ? mm[rb][int'(raddr_v_i) * H + int'(raddr_h_i)] : '0;
      if (busy0) begin
        mm[wb][DEPTH - clr_left] = clr_col;
        clr_left--;
        m_done = (clr_left == 0);
      end else begin
        m_done = 0;
        if (!done0 && clr_req_i) begin
          clr_left = DEPTH;
          clr_col  = clr_color_i;
        end
        if (we_i && int'(waddr_h_i) < H && int'(waddr_v_i) < V) begin
          idx = int'(waddr_v_i) * H + int'(waddr_h_i);
          for (int k = 0; k < LN; k++)
            if (wmask_i[k]) mm[wb][idx][8*k +: 8] = wdata_i[8*k +: 8];
        end
      end
      take   = DBUF && rise && (m_pend || swap_req_i) && !busy0;
      m_pend = DBUF && !take && (m_pend || swap_req_i);
      if (take) m_front = !m_front;
      vs2 = vs1;
      vs1 = vsync_i;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      check("rdata", rdata_o, m_rdata);
      check("rvalid", rvalid_o, m_rvalid);
      check("clr_busy", clr_busy_o, clr_left > 0);
      check("clr_done", clr_done_o, m_done);
      check("swap_pending", swap_pending_o, m_pend);
      check("front_sel", front_sel_o, m_front);
    end
  end

  task automatic wr(input int h, input int v, input logic [PW-1:0] d, input logic [LN-1:0] m);
    waddr_h_i = HW'(h); waddr_v_i = VW'(v); wdata_i = d; wmask_i = m; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int h, input int v, input logic [PW-1:0] exp);
    raddr_h_i = HW'(h); raddr_v_i = VW'(v); re_i = 1'b1;
    @(negedge clk);
    re_i = 1'b0;
    check(name, rdata_o, exp);
    check({name, "_valid"}, rvalid_o, 1);
  endtask

  task automatic start_clear(input logic [PW-1:0] c);
    clr_color_i = c; clr_req_i = 1'b1;
    @(negedge clk);
    clr_req_i = 1'b0;
  endtask

  task automatic do_clear(input logic [PW-1:0] c, input int poke);
    int n = 0;
    start_clear(c);
    while (clr_busy_o && n < 4 * DEPTH) begin
      if (n == poke) begin
        waddr_h_i = '0; waddr_v_i = '0; wdata_i = 24'h123456; wmask_i = '1; we_i = 1'b1;
      end else we_i = 1'b0;
      @(negedge clk);
      n++;
    end
    we_i = 1'b0;
    check("clr_busy_len", n, DEPTH);
    check("clr_done_at_end", clr_done_o, 1);
    @(negedge clk);
    check("clr_done_one_cycle", clr_done_o, 0);
  endtask

  task automatic flip();
    logic f0;
    f0 = front_sel_o;
    swap_req_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b0; vsync_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("flip_front", front_sel_o, f0 ^ DBUF);
    vsync_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_all(input logic [PW-1:0] c, input int poke);
    do_clear(c, poke);
    flip();
    do_clear(c, poke);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic f0;
    int   n;
    #2;
    check("rst_rdata", rdata_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_busy", clr_busy_o, 0);
    check("rst_done", clr_done_o, 0);
    check("rst_pending", swap_pending_o, 0);
    check("rst_front", front_sel_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; chk_en = 1;
    @(negedge clk);

    clear_all('0, -1);
    wr(6, 0, 24'hFFFFFF, '1);
    wr(0, 4, 24'hFFFFFF, '1);
    flip();
    rd_chk("oor_00", 0, 0, 24'h0);
    rd_chk("oor_01", 0, 1, 24'h0);
    rd_chk("oor_rd_60", 6, 0, 24'h0);

    wr(5, 3, 24'hAABBCC, 3'b111);
    wr(5, 3, 24'h112233, 3'b010);
    flip();
    rd_chk("masked", 5, 3, 24'hAA22CC);
    @(negedge clk);
    check("rdata_hold", rdata_o, 24'hAA22CC);

    clear_all(24'h00FF00, 10);
    rd_chk("clr_first", 0, 0, 24'h00FF00);
    rd_chk("clr_last", 5, 3, 24'h00FF00);

    // Request mid-frame, then the edge
    swap_req_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_held", swap_pending_o, DBUF);
    f0 = front_sel_o;
    vsync_i = 1'b1;
    @(negedge clk);
    check("swap_not_yet", front_sel_o, f0);
    @(negedge clk);
    check("swap_taken", front_sel_o, f0 ^ DBUF);
    check("pending_cleared", swap_pending_o, 0);
    vsync_i = 1'b0;
    repeat (2) @(negedge clk);

    // Request arriving in the edge cycle
    vsync_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b0;
    check("swap_back", front_sel_o, f0);
    vsync_i = 1'b0;
    repeat (2) @(negedge clk);

    // Edge while clearing is skipped
    f0 = front_sel_o;
    start_clear(24'h0000FF);
    swap_req_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b0; vsync_i = 1'b1;
    repeat (4) @(negedge clk);
    check("swap_blocked", front_sel_o, f0);
    check("swap_still_pending", swap_pending_o, DBUF);
    vsync_i = 1'b0;
    n = 0;
    while (clr_busy_o && n < 4 * DEPTH) begin @(negedge clk); n++; end
    check("clr_end_bound", clr_busy_o, 0);
    @(negedge clk);
    vsync_i = 1'b1;
    @(negedge clk); @(negedge clk);
    check("swap_after_clear", front_sel_o, f0 ^ DBUF);
    vsync_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during fill with a swap pending
    swap_req_i = 1'b1;
    @(negedge clk);
    swap_req_i = 1'b0;
    re_i = 1'b1;
    start_clear(24'h777777);
    re_i = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdata", rdata_o, 0);
    check("arst_rvalid", rvalid_o, 0);
    check("arst_busy", clr_busy_o, 0);
    check("arst_done", clr_done_o, 0);
    check("arst_pending", swap_pending_o, 0);
    check("arst_front", front_sel_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", clr_busy_o, 0);
    do_clear(24'h5A5A5A, -1);

    for (int i = 0; i < 1500; i++) begin
      we_i        = 1'($urandom);
      waddr_h_i   = HW'($urandom_range(0, 7));
      waddr_v_i   = VW'($urandom_range(0, 7));
      wmask_i     = LN'($urandom);
      wdata_i     = PW'($urandom);
      re_i        = 1'($urandom);
      raddr_h_i   = HW'($urandom_range(0, 7));
      raddr_v_i   = VW'($urandom_range(0, 7));
      clr_req_i   = ($urandom_range(0, 149) == 0);
      clr_color_i = PW'($urandom);
      swap_req_i  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) vsync_i = ~vsync_i;
      @(negedge clk);
    end
    we_i = 1'b0; re_i = 1'b0; clr_req_i = 1'b0; swap_req_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
